// File: rtl/ddr_btn_reporter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ddr_btn_reporter_pkg : event tag, button codes and sender FSM encodings |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
package ddr_btn_reporter_pkg;

  localparam int c_NUM_BTN = 5;
  localparam logic [2:0] c_EVT_TAG = 3'b101;
  // Index order matches i_btn = {BtnM,BtnR,BtnL,BtnD,BtnU}
  localparam logic [2:0] c_BTN_CODE [c_NUM_BTN] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  // WAIT_HI gives up on busy after four cycles (timer values 0..3)
  localparam logic [1:0] c_HI_TIMEOUT_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } sendState_t;

  function automatic logic [7:0] mkEvent(input logic press, input logic [2:0] code);
    return {c_EVT_TAG, press, 1'b0, code};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_debounce.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ddr_debounce : 2-flop synchronizer, stability counter, edge pulses      |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module ddr_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btnRaw,
  output logic o_rise,
  output logic o_fall
);

  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic [c_CNT_W-1:0] r_count;
  logic               r_rise;
  logic               r_fall;

  // Edge pulses are registered alongside the level so they coincide with its change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_count <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btnRaw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_count == c_LAST) begin
          r_level <= r_sync[1];
          r_rise  <= r_sync[1];
          r_fall  <= ~r_sync[1];
          r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ddr_btn_reporter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ddr_btn_reporter : debounced button press/release events to UART bytes  |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module ddr_btn_reporter
  import ddr_btn_reporter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [c_NUM_BTN-1:0] i_btn,
  input  logic                 i_tx_busy,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_stb,
  output logic                 o_overflow
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

  logic [c_NUM_BTN-1:0] w_rise, w_fall, w_clr;
  logic [c_NUM_BTN-1:0] r_pend, r_dir;
  logic [2:0]           w_sel;
  logic                 w_hit, w_full, w_pop, w_push, w_drop;
  logic [7:0]           w_evt;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [c_PTR_W:0]   r_count;

  sendState_t r_state;
  logic [1:0] r_timer;
  logic [7:0] r_txData;
  logic       r_txStb;
  logic       r_overflow;

  for (genvar g = 0; g < c_NUM_BTN; g++) begin : g_btn
    ddr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_btnRaw (i_btn[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

  // Fixed priority: the lowest index (BtnU) wins
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int i = c_NUM_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel = 3'(i);
        w_hit = 1'b1;
      end
    end
  end

  assign w_evt  = mkEvent(r_dir[w_sel], c_BTN_CODE[w_sel]);
  assign w_clr  = w_hit ? (c_NUM_BTN'(1) << w_sel) : '0;
  assign w_full = (r_count == c_FULL);
  assign w_pop  = (r_state == SEND);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push = w_hit && (!w_full || w_pop);
  assign w_drop = w_hit && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= '0;
      r_dir      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise | w_fall;
      r_dir  <= (r_dir & ~(w_rise | w_fall)) | w_rise;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_evt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_txStb  <= 1'b0;
      r_txData <= 8'h00;
    end else begin
      r_txStb <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((r_count != '0) && !i_tx_busy) begin
            r_state  <= SEND;
            r_txStb  <= 1'b1;
            r_txData <= r_mem[r_rdPtr];
          end
        end
        SEND: begin
          r_state <= WAIT_HI;
          r_timer <= '0;
        end
        WAIT_HI: begin
          if (i_tx_busy || (r_timer == c_HI_TIMEOUT_LAST)) begin
            r_state <= WAIT_LO;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!i_tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_data  = r_txData;
  assign o_tx_stb   = r_txStb;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ddr_btn_reporter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ddr_btn_reporter : scoreboard bench with a behavioural event model   |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_ddr_btn_reporter;

  localparam int DEB   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '0;
  logic       forceBusy = 1'b0;
  logic       respBusy  = 1'b0;
  logic       busy;
  logic [7:0] txData;
  logic       txStb;
  logic       ovf;

  assign busy = forceBusy | respBusy;

  ddr_btn_reporter #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn      (btn),
    .i_tx_busy  (busy),
    .o_tx_data  (txData),
    .o_tx_stb   (txStb),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0] expQ [$];
  logic [7:0] lastSent = 8'h00;
  logic       expOvf = 1'b0;
  int  sentCount = 0;
  int  lastStbCyc = 0;
  int  prevStbCyc = 0;
  bit  autoBusy = 0;
  bit  protoCheck = 0;
  int  phase = 3;
  bit  prevStb = 0;
  int  rd, rl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: each settled level change of a button is one event,
  // simultaneous changes are ordered U,D,L,R,M; with the UART held busy the
  // queue can hold DEPTH bytes and further events are dropped.
  task automatic setBtn(input logic [4:0] t);
    for (int i = 0; i < 5; i++) begin
      if (t[i] != btn[i]) begin
        if (forceBusy && expQ.size() >= DEPTH) expOvf = 1'b1;
        else expQ.push_back({3'b101, t[i], 1'b0, 3'(i)});
      end
    end
    btn = t;
  endtask

  task automatic waitDrain(input string name, input int maxCyc);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      tick(1);
      n++;
    end
    check(name, expQ.size(), 0);
  endtask

  task automatic applyReset(input logic [4:0] b);
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn = b;
    forceBusy = 1'b0;
    autoBusy = 0;
    protoCheck = 0;
    tick(1);
    @(negedge clk);
    check("reset stb", txStb, 0);
    check("reset data", txData, 8'h00);
    check("reset overflow", ovf, 0);
    tick(2);
    expQ.delete();
    lastSent = 8'h00;
    expOvf = 1'b0;
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every strobe, checks data hold otherwise
  always @(negedge clk) begin
    if (!rst) begin
      prevStb = 0;
      phase = 3;
    end else begin
      if (txStb) begin
        check("strobe one cycle", prevStb, 0);
        if (protoCheck) check("busy hi-lo before strobe", phase, 3);
        if (expQ.size() == 0) begin
          check("strobe with empty scoreboard", expQ.size(), 1);
        end else begin
          lastSent = expQ.pop_front();
          check("tx byte", txData, lastSent);
        end
        sentCount++;
        prevStbCyc = lastStbCyc;
        lastStbCyc = cyc;
        phase = 1;
      end else begin
        check("tx data hold", txData, lastSent);
        if (phase == 1 && busy) phase = 2;
        else if (phase == 2 && !busy) phase = 3;
      end
      prevStb = txStb;
    end
  end

  // UART responder: busy rises 0..2 cycles into WAIT_HI, lasts 1..3 cycles
  initial begin
    forever begin
      @(negedge clk);
      if (rst && txStb && autoBusy) begin
        rd = $urandom_range(0, 2);
        rl = $urandom_range(1, 3);
        tick(1);
        tick(rd);
        respBusy = 1'b1;
        tick(rl);
        respBusy = 1'b0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s0, n, g;
    logic [4:0] oldB, tgt, gm;

    applyReset(5'b00000);

    // Single press/release with idle UART: latency 2 sync + DEB + 3
    s0 = sentCount;
    setBtn(5'b00001);
    c0 = cyc;
    waitDrain("U press drain", 40);
    check("press latency", lastStbCyc - c0, 2 + DEB + 3);
    tick(10);
    setBtn(5'b00000);
    c0 = cyc;
    waitDrain("U release drain", 40);
    check("release latency", lastStbCyc - c0, 2 + DEB + 3);
    check("U press+release count", sentCount - s0, 2);

    // BtnL bouncing every 2 cycles never settles
    tick(10);
    s0 = sentCount;
    for (int k = 0; k < 10; k++) begin
      btn[2] = ~btn[2];
      tick(2);
    end
    tick(30);
    check("bounce gives no events", sentCount - s0, 0);
    check("bounce no overflow", ovf, expOvf);

    // U and M together, handshake with a responsive UART
    applyReset(5'b00000);
    protoCheck = 1;
    autoBusy = 1;
    s0 = sentCount;
    setBtn(5'b10001);
    waitDrain("U+M press drain", 100);
    tick(15);
    setBtn(5'b00000);
    waitDrain("U+M release drain", 100);
    tick(15);
    protoCheck = 0;
    check("U+M byte count", sentCount - s0, 4);

    // UART never asserts busy: SEND + 4 WAIT_HI + WAIT_LO + IDLE = 7 cycles
    applyReset(5'b00000);
    setBtn(5'b10001);
    waitDrain("timeout press drain", 60);
    check("timeout spacing press", lastStbCyc - prevStbCyc, 7);
    tick(15);
    setBtn(5'b00000);
    waitDrain("timeout release drain", 60);
    check("timeout spacing release", lastStbCyc - prevStbCyc, 7);

    // Busy held: 9 events into an 8-deep queue
    applyReset(5'b00000);
    forceBusy = 1'b1;
    s0 = sentCount;
    setBtn(5'b11111);
    tick(DEB + 12);
    check("no overflow at 5 events", ovf, expOvf);
    setBtn(5'b10000);
    tick(DEB + 12);
    check("overflow after 9 events", ovf, expOvf);
    check("nothing sent while busy", sentCount - s0, 0);
    forceBusy = 1'b0;
    autoBusy = 1;
    waitDrain("overflow drain", 300);
    tick(20);
    check("exactly 8 bytes sent", sentCount - s0, 8);
    check("overflow sticky", ovf, expOvf);
    autoBusy = 0;
    tick(10);

    // Reset in WAIT_LO with three bytes still queued
    applyReset(5'b00000);
    s0 = sentCount;
    setBtn(5'b01111);
    n = 0;
    while (sentCount == s0 && n < 40) begin
      tick(1);
      n++;
    end
    check("first byte before abort", sentCount - s0, 1);
    forceBusy = 1'b1;
    tick(6);
    applyReset(5'b00000);
    s0 = sentCount;
    tick(30);
    check("no strobe after abort", sentCount - s0, 0);
    setBtn(5'b01000);
    waitDrain("press after abort", 40);
    check("one byte after abort", sentCount - s0, 1);
    tick(10);
    setBtn(5'b00000);
    waitDrain("release after abort", 40);

    // Button held through reset release
    applyReset(5'b00010);
    expQ.push_back(8'hB1);
    waitDrain("held-through-reset press", 40);
    tick(10);
    setBtn(5'b00000);
    waitDrain("held-through-reset release", 40);

    // Randomized changes with sub-threshold glitches
    for (int step = 0; step < 30; step++) begin
      tick(12);
      autoBusy = ($urandom_range(0, 1) == 1);
      oldB = btn;
      tgt = 5'($urandom);
      gm = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'b00000;
      if (gm != 5'b00000) begin
        g = $urandom_range(1, DEB - 1);
        btn = oldB ^ gm;
        tick(g);
        btn = oldB;
        tick(1);
      end
      setBtn(tgt);
      tick(DEB + 4);
      waitDrain("random drain", 300);
    end
    tick(20);
    check("random no overflow", ovf, expOvf);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
